debug_unit: RTL and testbench
=============================

// Module: debug_unit
// PURPOSE
//  Host-side controller sitting directly upstream of the pipeline: drives its i_valid enable
//  from byte commands arriving over a UART receiver and counts executed clocks. After a step,
//  a halt or a dump command it streams a frame (PC, clock count, register file) to a UART transmitter.
// PARAMETERS
//  NB_REG         32     datapath / register width, multiple of NB_BYTE
//  NB_REG_ADDR    5      register file address width
//  REGFILE_DEPTH  32     registers dumped per frame, <= 2**NB_REG_ADDR
//  NB_BYTE        8      UART byte width
//  CMD_RUN        8'h63  'c': run continuously until halt
//  CMD_STEP       8'h73  's': execute exactly one clock
//  CMD_DUMP       8'h64  'd': send frame without executing
// PORTS
//  i_clock      in   1            system clock
//  i_reset      in   1            asynchronous, active-high reset
//  i_rx_data    in   NB_BYTE      received byte
//  i_rx_valid   in   1            one-cycle pulse, i_rx_data valid
//  o_tx_data    out  NB_BYTE      byte to transmit, stable from o_tx_start until i_tx_done
//  o_tx_start   out  1            one-cycle pulse, start transmission of o_tx_data
//  i_tx_done    in   1            one-cycle pulse, transmitter finished the byte
//  o_pipe_valid out  1            drives pipeline i_valid (pipeline advances when 1)
//  i_halt       in   1            pipeline retired HALT instruction
//  i_pc         in   NB_REG       current pipeline PC
//  o_reg_addr   out  NB_REG_ADDR  register file debug read address
//  i_reg_data   in   NB_REG       register file debug read data, combinational from o_reg_addr
//  o_n_clocks   out  NB_REG       clocks executed with o_pipe_valid=1
//  o_busy       out  1            1 in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; o_pipe_valid, o_tx_start, o_busy, o_tx_data, o_reg_addr, o_n_clocks,
//   halted flag, byte counter all 0. Reset mid-run or mid-frame aborts; no further o_tx_start.
//  States: IDLE, RUN, STEP, SNAP, TX_LOAD, TX_WAIT.
//  IDLE: act only on i_rx_valid. CMD_RUN -> RUN, CMD_STEP -> STEP (both ignored while halted=1),
//   CMD_DUMP -> SNAP. Other bytes ignored. i_rx_valid in any non-IDLE state is dropped.
//  RUN: o_pipe_valid=1 (registered, high the cycle after the command pulse). On i_halt=1:
//   set halted, o_pipe_valid=0 next cycle, -> SNAP.
//  STEP: o_pipe_valid=1 for exactly one cycle, then -> SNAP; i_halt sampled in STEP also sets halted.
//  o_n_clocks: +1 on every edge where o_pipe_valid=1; wraps modulo 2**NB_REG.
//  SNAP: latch i_pc and o_n_clocks into snapshot regs, byte counter=0, -> TX_LOAD.
//  Frame: word0=PC snap, word1=count snap, word2..=reg[0..REGFILE_DEPTH-1]; each word MSB byte
//   first; total FRAME_BYTES = (2+REGFILE_DEPTH)*NB_REG/NB_BYTE (136 for defaults).
//  o_reg_addr = word index-2 while sending register words, else 0; pipeline frozen so reads stable.
//  TX_LOAD: drive o_tx_data, pulse o_tx_start one cycle, -> TX_WAIT.
//  TX_WAIT: on i_tx_done: if byte counter = FRAME_BYTES-1 -> IDLE, else counter+1 -> TX_LOAD.
//   i_tx_done outside TX_WAIT ignored. No timeout.
//  halted clears only on i_reset; CMD_DUMP always allowed from IDLE.
//  o_pipe_valid is 0 in every state except RUN and STEP.
// TESTING
//  1 Reset, rx 's' -> o_pipe_valid high exactly 1 cycle, o_n_clocks=1, 136 tx bytes, bytes 4..7 = 00 00 00 01.
//  2 Preload reg[3]=32'hDEADBEEF, rx 'd' -> frame bytes 20..23 = DE AD BE EF, o_n_clocks stays 0.
//  3 rx 'c', assert i_halt after 10 valid cycles -> o_pipe_valid drops next cycle, frame count word = 11.
//  4 After halt, rx 's' and 'c' -> ignored, o_pipe_valid stays 0, no tx; rx 'd' -> frame sent.
//  5 rx bytes during TX_WAIT and spurious i_tx_done in IDLE -> no state change, no extra tx pulse.
//  6 Assert i_reset at byte 50 of a frame -> all outputs 0 immediately, no further o_tx_start.

Source files
------------

// File: rtl/debug_unit.sv
// Host-side debug controller: gates the pipeline from UART byte commands, counts
// executed clocks and streams a PC / clock-count / register-file frame back over UART.
module debug_unit #(
    parameter int                 NB_REG        = 32,
    parameter int                 NB_REG_ADDR   = 5,
    parameter int                 REGFILE_DEPTH = 32,
    parameter int                 NB_BYTE       = 8,
    parameter logic [NB_BYTE-1:0] CMD_RUN       = 8'h63,
    parameter logic [NB_BYTE-1:0] CMD_STEP      = 8'h73,
    parameter logic [NB_BYTE-1:0] CMD_DUMP      = 8'h64
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_BYTE-1:0]     i_rx_data,
    input  logic                   i_rx_valid,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_pipe_valid,
    input  logic                   i_halt,
    input  logic [NB_REG-1:0]      i_pc,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_REG-1:0]      i_reg_data,
    output logic [NB_REG-1:0]      o_n_clocks,
    output logic                   o_busy
);

    localparam int BYTES_PER_WORD = NB_REG / NB_BYTE;
    localparam int FRAME_BYTES    = (2 + REGFILE_DEPTH) * BYTES_PER_WORD;
    localparam int CNT_W          = $clog2(FRAME_BYTES);
    localparam int SEL_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] BPW_C     = CNT_W'(BYTES_PER_WORD);

    typedef enum logic [2:0] {IDLE, RUN, STEP, SNAP, TX_LOAD, TX_WAIT} state_t;

    state_t             state_reg, state_next;
    logic               halted_reg, halted_next;
    logic [CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
    logic [NB_REG-1:0]  n_clocks_reg;
    logic [NB_REG-1:0]  pc_snap_reg;
    logic [NB_REG-1:0]  cnt_snap_reg;
    logic               sending;
    logic [CNT_W-1:0]   word_idx;
    logic [SEL_W-1:0]   byte_sel;
    logic [NB_REG-1:0]  word_sel;
    logic [NB_BYTE-1:0] word_bytes [BYTES_PER_WORD];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            halted_reg   <= 1'b0;
            byte_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            halted_reg   <= halted_next;
            byte_cnt_reg <= byte_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        halted_next   = halted_reg;
        byte_cnt_next = byte_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_RUN && !halted_reg)       state_next = RUN;
                    else if (i_rx_data == CMD_STEP && !halted_reg) state_next = STEP;
                    else if (i_rx_data == CMD_DUMP)                state_next = SNAP;
                end
            end
            RUN: begin
                if (i_halt) begin
                    halted_next = 1'b1;
                    state_next  = SNAP;
                end
            end
            STEP: begin
                if (i_halt) halted_next = 1'b1;
                state_next = SNAP;
            end
            SNAP: begin
                byte_cnt_next = '0;
                state_next    = TX_LOAD;
            end
            TX_LOAD: state_next = TX_WAIT;
            TX_WAIT: begin
                if (i_tx_done) begin
                    if (byte_cnt_reg == LAST_BYTE) begin
                        state_next = IDLE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + CNT_W'(1);
                        state_next    = TX_LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_pipe_valid = (state_reg == RUN) || (state_reg == STEP);
        o_tx_start   = (state_reg == TX_LOAD);
        sending      = (state_reg == TX_LOAD) || (state_reg == TX_WAIT);
        o_busy       = (state_reg != IDLE);
    end

    // Clock counter and frame snapshots; the pipeline is frozen while the frame streams.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            n_clocks_reg <= '0;
            pc_snap_reg  <= '0;
            cnt_snap_reg <= '0;
        end else begin
            if (o_pipe_valid) n_clocks_reg <= n_clocks_reg + NB_REG'(1);
            if (state_reg == SNAP) begin
                pc_snap_reg  <= i_pc;
                cnt_snap_reg <= n_clocks_reg;
            end
        end
    end

    always_comb begin
        word_idx = byte_cnt_reg / BPW_C;
        byte_sel = SEL_W'(byte_cnt_reg % BPW_C);
        if (word_idx == '0)             word_sel = pc_snap_reg;
        else if (word_idx == CNT_W'(1)) word_sel = cnt_snap_reg;
        else                            word_sel = i_reg_data;
    end

    // Byte 0 of each word is its most significant byte.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_word_bytes
            assign word_bytes[gi] = word_sel[(BYTES_PER_WORD-1-gi)*NB_BYTE +: NB_BYTE];
        end
    endgenerate

    assign o_tx_data  = sending ? word_bytes[byte_sel] : '0;
    assign o_reg_addr = (sending && word_idx >= CNT_W'(2)) ? NB_REG_ADDR'(word_idx - CNT_W'(2)) : '0;
    assign o_n_clocks = n_clocks_reg;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: random commands, register contents and UART
// handshake timing, checked against a frame/clock-count model built from the command rules.
`timescale 1ns/1ps
module tb_debug_unit;

    localparam int NB_REG      = 32;
    localparam int NB_REG_ADDR = 5;
    localparam int DEPTH       = 32;
    localparam int NB_BYTE     = 8;
    localparam int BPW         = NB_REG / NB_BYTE;
    localparam int FRAME_BYTES = (2 + DEPTH) * BPW;
    localparam logic [7:0] C_RUN  = 8'h63;
    localparam logic [7:0] C_STEP = 8'h73;
    localparam logic [7:0] C_DUMP = 8'h64;

    logic                   i_clock    = 1'b0;
    logic                   i_reset    = 1'b0;
    logic [NB_BYTE-1:0]     i_rx_data  = '0;
    logic                   i_rx_valid = 1'b0;
    logic                   i_tx_done  = 1'b0;
    logic                   i_halt     = 1'b0;
    logic [NB_REG-1:0]      i_pc       = '0;
    logic [NB_REG-1:0]      i_reg_data;
    logic [NB_BYTE-1:0]     o_tx_data;
    logic                   o_tx_start;
    logic                   o_pipe_valid;
    logic [NB_REG_ADDR-1:0] o_reg_addr;
    logic [NB_REG-1:0]      o_n_clocks;
    logic                   o_busy;

    logic [NB_REG-1:0] regs [DEPTH];
    logic [7:0]        got [$];
    logic [31:0]       model_clocks = '0;
    bit                model_halted = 1'b0;
    int                tests_run    = 0;
    int                tests_failed = 0;

    assign i_reg_data = regs[o_reg_addr];

    always #5 i_clock = ~i_clock;

    debug_unit dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_done    (i_tx_done),
        .o_pipe_valid (o_pipe_valid),
        .i_halt       (i_halt),
        .i_pc         (i_pc),
        .o_reg_addr   (o_reg_addr),
        .i_reg_data   (i_reg_data),
        .o_n_clocks   (o_n_clocks),
        .o_busy       (o_busy)
    );

    task automatic apply_reset();
        i_reset = 1'b1; i_rx_valid = 1'b0; i_tx_done = 1'b0; i_halt = 1'b0;
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);
        model_clocks = '0;
        model_halted = 1'b0;
    endtask

    task automatic randomize_state();
        for (int i = 0; i < DEPTH; i++) regs[i] = $urandom();
        i_pc = $urandom();
    endtask

    // Sends one command byte and plays the pipeline/UART side until the unit is idle again.
    task automatic exec_cmd(input logic [7:0] cmd, input int halt_after, input bit inject_rx,
                            input int abort_at, output int valid_cycles, output int errs);
        logic [7:0] cur;
        int         waitc;
        bit         pending, done, aborted;
        got.delete();
        valid_cycles = 0; errs = 0; pending = 0; done = 0; aborted = 0; waitc = 0; cur = '0;
        i_rx_data = cmd; i_rx_valid = 1'b1;
        @(negedge i_clock);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_rx_valid = 1'b0; i_tx_done = 1'b0; i_halt = 1'b0;
            if (!o_busy) begin done = 1; break; end
            if (o_pipe_valid) begin
                valid_cycles++;
                if (halt_after >= 0 && valid_cycles == halt_after + 1) i_halt = 1'b1;
            end
            if (pending) begin
                if (o_tx_data !== cur) errs++;
                if (o_tx_start) errs++;
                waitc--;
                if (waitc == 0) begin
                    i_tx_done = 1'b1;
                    pending = 0;
                end else if (inject_rx) begin
                    i_rx_valid = 1'b1;
                    case ($urandom_range(0, 2))
                        0:       i_rx_data = C_RUN;
                        1:       i_rx_data = C_STEP;
                        default: i_rx_data = C_DUMP;
                    endcase
                end
            end else if (o_tx_start) begin
                cur = o_tx_data;
                got.push_back(cur);
                pending = 1;
                waitc = $urandom_range(1, 3);
                i_pc = $urandom();
                if (got.size() == abort_at) begin aborted = 1; break; end
            end
            @(negedge i_clock);
        end
        i_rx_valid = 1'b0; i_halt = 1'b0;
        if (!aborted) i_tx_done = 1'b0;
        if (!done && !aborted) errs++;
        $display("[TB] cmd 0x%02h: pipe_valid cycles=%0d, tx bytes=%0d, protocol errors=%0d",
                 cmd, valid_cycles, got.size(), errs);
    endtask

    // Expected frame: PC, clock count, then every register, most significant byte first.
    function automatic int frame_diff(input logic [31:0] pc, input logic [31:0] cnt,
                                      output int first, output logic [7:0] g, output logic [7:0] e);
        logic [7:0]  exp_q [$];
        logic [31:0] word;
        int          n;
        for (int w = 0; w < 2 + DEPTH; w++) begin
            word = (w == 0) ? pc : ((w == 1) ? cnt : regs[w-2]);
            for (int b = BPW - 1; b >= 0; b--) exp_q.push_back(word[b*NB_BYTE +: NB_BYTE]);
        end
        n = 0; first = -1; g = '0; e = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                if (first < 0) begin
                    first = i; e = exp_q[i];
                    g = (i < got.size()) ? got[i] : 8'h00;
                end
                n++;
            end
        end
        return n;
    endfunction

    task automatic test_reset();
        #2 i_reset = 1'b1;
        #1;
        tests_run++;
        if ({o_pipe_valid, o_tx_start, o_busy, o_tx_data, o_reg_addr, o_n_clocks} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b start=%b busy=%b data=%h addr=%h clocks=%h, all required 0",
                     o_pipe_valid, o_tx_start, o_busy, o_tx_data, o_reg_addr, o_n_clocks);
        end
        i_rx_data = C_RUN; i_rx_valid = 1'b1;
        repeat (2) @(negedge i_clock);
        tests_run++;
        if ({o_pipe_valid, o_busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_holds: valid=%b busy=%b, required 00 while reset held", o_pipe_valid, o_busy);
        end
        i_rx_valid = 1'b0; i_reset = 1'b0;
        @(negedge i_clock);
        tests_run++;
        if ({o_pipe_valid, o_tx_start, o_busy, o_n_clocks} !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle: valid=%b start=%b busy=%b clocks=%h, all required 0",
                     o_pipe_valid, o_tx_start, o_busy, o_n_clocks);
        end
        model_clocks = '0; model_halted = 1'b0;
    endtask

    task automatic test_step();
        int v, errs, n, first; logic [7:0] g, e; logic [31:0] pc, cw;
        apply_reset(); randomize_state(); pc = i_pc;
        exec_cmd(C_STEP, -1, 1'b0, 0, v, errs);
        model_clocks = 32'd1;
        tests_run++;
        if (v !== 1) begin tests_failed++; $display("FAIL step_valid: %0d cycles, required 1", v); end
        tests_run++;
        if (errs !== 0) begin tests_failed++; $display("FAIL step_protocol: %0d errors, required 0", errs); end
        tests_run++;
        if (got.size() !== FRAME_BYTES) begin
            tests_failed++; $display("FAIL step_len: %0d bytes, required %0d", got.size(), FRAME_BYTES);
        end
        cw = (got.size() >= 8) ? {got[4], got[5], got[6], got[7]} : 32'hFFFF_FFFF;
        tests_run++;
        if (cw !== 32'h0000_0001) begin tests_failed++; $display("FAIL step_count_word: %h, required 00000001", cw); end
        n = frame_diff(pc, model_clocks, first, g, e);
        tests_run++;
        if (n !== 0) begin
            tests_failed++; $display("FAIL step_frame: %0d bad bytes, first @%0d got %h required %h", n, first, g, e);
        end
        tests_run++;
        if (o_n_clocks !== model_clocks) begin
            tests_failed++; $display("FAIL step_n_clocks: %0d, required %0d", o_n_clocks, model_clocks);
        end
    endtask

    task automatic test_dump();
        int v, errs, n, first; logic [7:0] g, e; logic [31:0] pc, rw;
        apply_reset(); randomize_state(); regs[3] = 32'hDEAD_BEEF; pc = i_pc;
        exec_cmd(C_DUMP, -1, 1'b0, 0, v, errs);
        tests_run++;
        if (v !== 0 || errs !== 0) begin
            tests_failed++; $display("FAIL dump_quiet: valid=%0d errors=%0d, required 0 and 0", v, errs);
        end
        rw = (got.size() >= 24) ? {got[20], got[21], got[22], got[23]} : 32'h0;
        tests_run++;
        if (rw !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL dump_reg3: %h, required deadbeef", rw); end
        n = frame_diff(pc, 32'd0, first, g, e);
        tests_run++;
        if (n !== 0 || got.size() !== FRAME_BYTES) begin
            tests_failed++;
            $display("FAIL dump_frame: %0d bad bytes of %0d, first @%0d got %h required %h", n, got.size(), first, g, e);
        end
        tests_run++;
        if (o_n_clocks !== 32'd0) begin tests_failed++; $display("FAIL dump_n_clocks: %0d, required 0", o_n_clocks); end
    endtask

    task automatic test_run_halt();
        int v, errs, n, first; logic [7:0] g, e; logic [31:0] pc, cw;
        apply_reset(); randomize_state(); pc = i_pc;
        exec_cmd(C_RUN, 10, 1'b0, 0, v, errs);
        model_clocks = 32'd11; model_halted = 1'b1;
        tests_run++;
        if (v !== 11 || errs !== 0) begin
            tests_failed++; $display("FAIL run_valid: %0d cycles errors=%0d, required 11 and 0", v, errs);
        end
        cw = (got.size() >= 8) ? {got[4], got[5], got[6], got[7]} : 32'h0;
        tests_run++;
        if (cw !== 32'd11) begin tests_failed++; $display("FAIL run_count_word: %0d, required 11", cw); end
        n = frame_diff(pc, model_clocks, first, g, e);
        tests_run++;
        if (n !== 0 || got.size() !== FRAME_BYTES) begin
            tests_failed++;
            $display("FAIL run_frame: %0d bad bytes of %0d, first @%0d got %h required %h", n, got.size(), first, g, e);
        end
    endtask

    task automatic test_halted_ignore();
        int v, errs, n, first; logic [7:0] g, e; logic [31:0] pc;
        logic [7:0] cmds [3];
        cmds[0] = C_STEP; cmds[1] = C_RUN; cmds[2] = 8'h41;
        for (int k = 0; k < 3; k++) begin
            exec_cmd(cmds[k], -1, 1'b0, 0, v, errs);
            tests_run++;
            if (v !== 0 || got.size() !== 0 || errs !== 0) begin
                tests_failed++;
                $display("FAIL halted_ignore_%02h: valid=%0d bytes=%0d errors=%0d, required 0 0 0", cmds[k], v, got.size(), errs);
            end
        end
        pc = i_pc;
        exec_cmd(C_DUMP, -1, 1'b0, 0, v, errs);
        n = frame_diff(pc, model_clocks, first, g, e);
        tests_run++;
        if (n !== 0 || got.size() !== FRAME_BYTES || v !== 0) begin
            tests_failed++;
            $display("FAIL halted_dump: %0d bad bytes of %0d valid=%0d, first @%0d got %h required %h", n, got.size(), v, first, g, e);
        end
    endtask

    task automatic test_rx_during_tx();
        int v, errs, n, first, bad; logic [7:0] g, e; logic [31:0] pc;
        apply_reset(); randomize_state(); pc = i_pc;
        exec_cmd(C_STEP, -1, 1'b1, 0, v, errs);
        model_clocks = 32'd1;
        n = frame_diff(pc, model_clocks, first, g, e);
        tests_run++;
        if (n !== 0 || got.size() !== FRAME_BYTES || v !== 1 || errs !== 0) begin
            tests_failed++;
            $display("FAIL rx_in_tx: %0d bad bytes of %0d valid=%0d errors=%0d, required 0 %0d 1 0", n, got.size(), v, errs, FRAME_BYTES);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            i_tx_done = i[0];
            @(negedge i_clock);
            if (o_busy || o_tx_start) bad++;
        end
        i_tx_done = 1'b0;
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL spurious_done: %0d active cycles, required 0", bad); end
        tests_run++;
        if (o_n_clocks !== model_clocks) begin
            tests_failed++; $display("FAIL spurious_n_clocks: %0d, required %0d", o_n_clocks, model_clocks);
        end
    endtask

    task automatic test_reset_midframe();
        int v, errs, starts, busy, n, first; logic [7:0] g, e; logic [31:0] pc;
        apply_reset(); randomize_state();
        exec_cmd(C_RUN, $urandom_range(0, 8), 1'b0, 0, v, errs);
        exec_cmd(C_DUMP, -1, 1'b0, 51, v, errs);
        tests_run++;
        if (got.size() !== 51 || errs !== 0) begin
            tests_failed++; $display("FAIL abort_setup: %0d bytes errors=%0d, required 51 and 0", got.size(), errs);
        end
        i_reset = 1'b1;
        #1;
        tests_run++;
        if ({o_pipe_valid, o_tx_start, o_busy, o_tx_data, o_reg_addr, o_n_clocks} !== '0) begin
            tests_failed++;
            $display("FAIL abort_outputs: valid=%b start=%b busy=%b data=%h addr=%h clocks=%h, all required 0",
                     o_pipe_valid, o_tx_start, o_busy, o_tx_data, o_reg_addr, o_n_clocks);
        end
        @(negedge i_clock);
        i_reset = 1'b0; model_clocks = '0; model_halted = 1'b0;
        starts = 0; busy = 0;
        for (int i = 0; i < 300; i++) begin
            i_tx_done = (i % 3 == 0);
            @(negedge i_clock);
            if (o_tx_start) starts++;
            if (o_busy) busy++;
        end
        i_tx_done = 1'b0;
        tests_run++;
        if (starts !== 0 || busy !== 0) begin
            tests_failed++; $display("FAIL abort_silent: %0d starts %0d busy cycles, required 0 and 0", starts, busy);
        end
        pc = i_pc;
        exec_cmd(C_STEP, -1, 1'b0, 0, v, errs);
        model_clocks = 32'd1;
        n = frame_diff(pc, model_clocks, first, g, e);
        tests_run++;
        if (v !== 1 || n !== 0 || got.size() !== FRAME_BYTES) begin
            tests_failed++;
            $display("FAIL halt_cleared: valid=%0d %0d bad bytes of %0d, required 1 0 %0d", v, n, got.size(), FRAME_BYTES);
        end
    endtask

    task automatic test_back_to_back();
        int v, errs, n, first, h, exp_v; bit exp_frame; logic [7:0] cmd, g, e; logic [31:0] pc;
        apply_reset();
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 5) == 0) apply_reset();
            randomize_state(); pc = i_pc;
            h = -1; exp_v = 0; exp_frame = 0;
            case ($urandom_range(0, 3))
                0: begin
                    cmd = C_RUN; h = $urandom_range(0, 15);
                    if (!model_halted) begin exp_v = h + 1; exp_frame = 1; model_halted = 1; end
                end
                1: begin
                    cmd = C_STEP;
                    if ($urandom_range(0, 2) == 0) h = 0;
                    if (!model_halted) begin exp_v = 1; exp_frame = 1; if (h == 0) model_halted = 1; end
                end
                2: begin cmd = C_DUMP; exp_frame = 1; end
                default: begin
                    do cmd = 8'($urandom_range(0, 255)); while (cmd == C_RUN || cmd == C_STEP || cmd == C_DUMP);
                end
            endcase
            model_clocks = model_clocks + 32'(exp_v);
            exec_cmd(cmd, h, 1'($urandom_range(0, 1)), 0, v, errs);
            tests_run++;
            if (v !== exp_v || errs !== 0) begin
                tests_failed++;
                $display("FAIL b2b_%0d_valid: cmd %h valid=%0d errors=%0d, required %0d and 0", it, cmd, v, errs, exp_v);
            end
            tests_run++;
            if (got.size() !== (exp_frame ? FRAME_BYTES : 0)) begin
                tests_failed++;
                $display("FAIL b2b_%0d_len: cmd %h %0d bytes, required %0d", it, cmd, got.size(), exp_frame ? FRAME_BYTES : 0);
            end
            if (exp_frame) begin
                n = frame_diff(pc, model_clocks, first, g, e);
                tests_run++;
                if (n !== 0) begin
                    tests_failed++;
                    $display("FAIL b2b_%0d_frame: %0d bad bytes, first @%0d got %h required %h", it, n, first, g, e);
                end
            end
            tests_run++;
            if (o_n_clocks !== model_clocks) begin
                tests_failed++; $display("FAIL b2b_%0d_n_clocks: %0d, required %0d", it, o_n_clocks, model_clocks);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) regs[i] = '0;
        test_reset();
        test_step();
        test_dump();
        test_run_halt();
        test_halted_ignore();
        test_rx_during_tx();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
